// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared constants for the reset sequencer: FSM state encoding, reset-cause
// codes, counter width and a saturating increment helper.
package reset_seq_pkg;

   localparam int CNT_W = 16;

   localparam logic [1:0] CAUSE_POR  = 2'b01;
   localparam logic [1:0] CAUSE_SOFT = 2'b10;

   localparam logic [2:0] ST_WAIT_POR = 3'd0;
   localparam logic [2:0] ST_HOLD     = 3'd1;
   localparam logic [2:0] ST_RELEASE  = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_ACK_WAIT = 3'd4;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Soft-reset handshake and sequenced-reset status bundle.
//   soft_req     requester -> sequencer, four-phase level request
//   soft_ack     sequencer -> requester, completion acknowledge
//   resetn_stage sequencer -> SoC, active-low per-domain resets
//   seq_busy     high while any domain is held in reset
//   last_cause   01 = POR/reset, 10 = soft request
interface reset_sequencer_if #(
   parameter int NSTAGES = 3
);
   logic               soft_req;
   logic               soft_ack;
   logic [NSTAGES-1:0] resetn_stage;
   logic               seq_busy;
   logic [1:0]         last_cause;

   modport master (
      output soft_req,
      input  soft_ack,
      input  resetn_stage,
      input  seq_busy,
      input  last_cause
   );

   modport slave (
      input  soft_req,
      output soft_ack,
      output resetn_stage,
      output seq_busy,
      output last_cause
   );
endinterface

// File: rtl/sync2.sv
// sync2
// Two-flop synchronizer with asynchronous active-high clear.
//   clk  sampling clock
//   clr  async clear, forces q to 0 immediately
//   d    asynchronous input
//   q    synchronized output, two edges behind d
module sync2 (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Turns the board POR into ordered active-low domain resets (stage 0 first)
// and re-runs the sequence on a four-phase soft-reset request.
//   clock48     48 MHz board clock
//   reset       async active-high, deassertion synchronized internally
//   por_resetn  active-low POR, synchronized before use
//   seq         slave side of reset_sequencer_if (soft_req/soft_ack,
//               resetn_stage, seq_busy, last_cause), all outputs registered
//
// state       | meaning
// WAIT_POR    | all domains in reset, waiting for POR release
// HOLD        | all domains in reset, counting HOLD_CLOCKS
// RELEASE     | releasing one domain every STAGE_GAP cycles
// RUN         | all domains released, watching soft_req
// ACK_WAIT    | soft sequence done, soft_ack high until soft_req drops
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NSTAGES     = 3,
   parameter int HOLD_CLOCKS = 32,
   parameter int STAGE_GAP   = 16
) (
   input  logic              clock48,
   input  logic              reset,
   input  logic              por_resetn,
   reset_sequencer_if.slave  seq
);

   localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CLOCKS - 1);
   localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(STAGE_GAP - 1);
   localparam logic [NSTAGES-1:0] STAGE_FIRST = NSTAGES'(1);

   logic rst_release;
   logic rst_core;
   logic por_s;
   logic soft_s;

   // Assertion of reset clears this synchronizer at once, so rst_core rises
   // without a clock; it only falls two edges after reset is removed.
   sync2 u_rst_sync (
      .clk (clock48),
      .clr (reset),
      .d   (1'b1),
      .q   (rst_release)
   );

   assign rst_core = ~rst_release;

   sync2 u_por_sync (
      .clk (clock48),
      .clr (rst_core),
      .d   (por_resetn),
      .q   (por_s)
   );

   sync2 u_soft_sync (
      .clk (clock48),
      .clr (rst_core),
      .d   (seq.soft_req),
      .q   (soft_s)
   );

   logic [2:0]         state_q, state_d;
   logic [NSTAGES-1:0] stage_q, stage_d;
   logic [1:0]         cause_q, cause_d;
   logic               ack_q, ack_d;
   logic               busy_q;
   logic [CNT_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic               release_now;

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      cause_d     = cause_q;
      ack_d       = ack_q;
      hold_d      = hold_q;
      gap_d       = gap_q;
      release_now = 1'b0;

      case (state_q)
         ST_WAIT_POR: begin
            stage_d = '0;
            hold_d  = '0;
            gap_d   = '0;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            hold_d = sat_inc(hold_q);
            if (hold_q == HOLD_LAST) begin
               stage_d     = STAGE_FIRST;
               gap_d       = '0;
               release_now = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (gap_q == GAP_LAST) begin
               // resetn_stage is a thermometer: released domains are the low bits
               stage_d     = (stage_q << 1) | STAGE_FIRST;
               gap_d       = '0;
               release_now = 1'b1;
            end else begin
               gap_d = sat_inc(gap_q);
            end
         end
         ST_RUN: begin
            if (soft_s && !ack_q) begin
               stage_d = '0;
               cause_d = CAUSE_SOFT;
               hold_d  = '0;
               gap_d   = '0;
               state_d = ST_HOLD;
            end
         end
         ST_ACK_WAIT: begin
            if (!soft_s) begin
               ack_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
         default: begin
            stage_d = '0;
            state_d = ST_WAIT_POR;
         end
      endcase

      if (release_now) begin
         if (&stage_d) begin
            if (cause_q == CAUSE_SOFT) begin
               ack_d   = 1'b1;
               state_d = ST_ACK_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end else begin
            state_d = ST_RELEASE;
         end
      end

      // POR loss wins over everything, including a soft request seen on the same edge.
      if (!por_s) begin
         stage_d = '0;
         cause_d = CAUSE_POR;
         ack_d   = 1'b0;
         hold_d  = '0;
         gap_d   = '0;
         state_d = ST_WAIT_POR;
      end
   end

   always_ff @(posedge clock48 or posedge rst_core) begin
      if (rst_core) begin
         state_q <= ST_WAIT_POR;
         stage_q <= '0;
         cause_q <= CAUSE_POR;
         ack_q   <= 1'b0;
         busy_q  <= 1'b1;
         hold_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cause_q <= cause_d;
         ack_q   <= ack_d;
         busy_q  <= ~&stage_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
      end
   end

   assign seq.resetn_stage = stage_q;
   assign seq.seq_busy     = busy_q;
   assign seq.last_cause   = cause_q;
   assign seq.soft_ack     = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Drives two sequencer instances (default timing and HOLD=1/GAP=1) with
// randomized delays and compares every cycle against release times computed
// arithmetically from the hold/gap rules.
module tb_reset_sequencer;

   localparam int N  = 3;
   localparam int HD = 32;
   localparam int GD = 16;
   localparam int HF = 1;
   localparam int GF = 1;

   localparam logic [1:0]   C_POR  = 2'b01;
   localparam logic [1:0]   C_SOFT = 2'b10;
   localparam logic [N-1:0] ALL    = '1;

   logic clock48;
   logic reset;
   logic por_resetn;

   int tests_run    = 0;
   int tests_failed = 0;

   reset_sequencer_if #(.NSTAGES(N)) if_d ();
   reset_sequencer_if #(.NSTAGES(N)) if_f ();

   reset_sequencer #(.NSTAGES(N), .HOLD_CLOCKS(HD), .STAGE_GAP(GD)) dut (
      .clock48    (clock48),
      .reset      (reset),
      .por_resetn (por_resetn),
      .seq        (if_d)
   );

   reset_sequencer #(.NSTAGES(N), .HOLD_CLOCKS(HF), .STAGE_GAP(GF)) dut_f (
      .clock48    (clock48),
      .reset      (reset),
      .por_resetn (por_resetn),
      .seq        (if_f)
   );

   initial clock48 = 1'b0;
   always #10 clock48 = ~clock48;

   // Number of domains released t edges after HOLD entry.
   function automatic int released(input int t, input int h, input int g);
      int n;
      if (t < h) return 0;
      n = 1 + (t - h) / g;
      return (n > N) ? N : n;
   endfunction

   function automatic logic [N-1:0] stages_for(input int n);
      logic [N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++)
         if (k < n) v[k] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clock48);
      #1;
   endtask

   task automatic set_soft(input bit sel, input logic v);
      if (sel) if_f.soft_req = v;
      else     if_d.soft_req = v;
   endtask

   task automatic get_obs(input bit sel, output logic [N-1:0] st, output logic busy,
                          output logic [1:0] cause, output logic ack);
      st    = sel ? if_f.resetn_stage : if_d.resetn_stage;
      busy  = sel ? if_f.seq_busy     : if_d.seq_busy;
      cause = sel ? if_f.last_cause   : if_d.last_cause;
      ack   = sel ? if_f.soft_ack     : if_d.soft_ack;
   endtask

   task automatic check_all(input string name, input int i, input logic [N-1:0] exp_st,
                            input logic [1:0] exp_cause, input logic exp_ack, input bit sel);
      logic [N-1:0] st;
      logic busy, ack;
      logic [1:0] cause;
      get_obs(sel, st, busy, cause, ack);
      tests_run++;
      if (st !== exp_st) begin
         tests_failed++;
         $display("FAIL %s stages @%0d: got %b want %b", name, i, st, exp_st);
      end
      tests_run++;
      if (busy !== (exp_st != ALL)) begin
         tests_failed++;
         $display("FAIL %s busy @%0d: got %b want %b", name, i, busy, exp_st != ALL);
      end
      tests_run++;
      if (cause !== exp_cause) begin
         tests_failed++;
         $display("FAIL %s cause @%0d: got %b want %b", name, i, cause, exp_cause);
      end
      tests_run++;
      if (ack !== exp_ack) begin
         tests_failed++;
         $display("FAIL %s ack @%0d: got %b want %b", name, i, ack, exp_ack);
      end
   endtask

   // lead = edges from stimulus to HOLD entry; limit > 0 stops early.
   task automatic check_sequence(input bit sel, input int lead, input bit pre_rel,
                                 input logic [1:0] cause_pre, input logic [1:0] cause_exp,
                                 input bit soft_run, input int limit, input string name);
      int h, g, total, t;
      logic [N-1:0] exp_st;
      logic [1:0] exp_cause;
      logic exp_ack;
      h = sel ? HF : HD;
      g = sel ? GF : GD;
      total = lead + h + (N - 1) * g;
      if (limit > 0) total = limit;
      for (int i = 1; i <= total; i++) begin
         tick();
         t = i - lead;
         if (t < 0) begin
            exp_st    = pre_rel ? ALL : '0;
            exp_cause = cause_pre;
         end else begin
            exp_st    = stages_for(released(t, h, g));
            exp_cause = cause_exp;
         end
         exp_ack = soft_run && (t >= 0) && (exp_st == ALL);
         check_all(name, i, exp_st, exp_cause, exp_ack, sel);
      end
   endtask

   task automatic ack_handshake(input bit sel, input string name);
      int hold;
      hold = $urandom_range(1, 12);
      for (int i = 1; i <= hold; i++) begin
         tick();
         check_all({name, "_hold"}, i, ALL, C_SOFT, 1'b1, sel);
      end
      set_soft(sel, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_all({name, "_drop"}, i, ALL, C_SOFT, (i < 3), sel);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      check_all("reset_d", 0, '0, C_POR, 1'b0, 1'b0);
      check_all("reset_f", 0, '0, C_POR, 1'b0, 1'b1);
   endtask

   task automatic test_min_params();
      int w;
      reset = 1'b1;
      por_resetn = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      w = $urandom_range(4, 10);
      for (int i = 1; i <= w; i++) tick();
      por_resetn = 1'b1;
      check_sequence(1'b1, 3, 1'b0, C_POR, C_POR, 1'b0, 0, "min_por");
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_all("min_run", i, ALL, C_POR, 1'b0, 1'b1);
      end
      set_soft(1'b1, 1'b1);
      check_sequence(1'b1, 3, 1'b1, C_POR, C_SOFT, 1'b1, 0, "min_soft");
      ack_handshake(1'b1, "min_ack");
   endtask

   task automatic test_por_startup();
      int w;
      reset = 1'b1;
      por_resetn = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      w = $urandom_range(4, 12);
      for (int i = 1; i <= w; i++) begin
         tick();
         check_all("wait_por", i, '0, C_POR, 1'b0, 1'b0);
      end
      por_resetn = 1'b1;
      check_sequence(1'b0, 3, 1'b0, C_POR, C_POR, 1'b0, 0, "por_startup");
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_all("por_run", i, ALL, C_POR, 1'b0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         set_soft(1'b0, 1'b1);
         check_sequence(1'b0, 3, 1'b1, (k == 0) ? C_POR : C_SOFT, C_SOFT, 1'b1, 0, "soft");
         ack_handshake(1'b0, "soft_ack");
      end
   endtask

   task automatic test_por_soft_same();
      int w;
      set_soft(1'b0, 1'b1);
      por_resetn = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i < 3) check_all("same_pre", i, ALL, C_SOFT, 1'b0, 1'b0);
         else       check_all("same_por", i, '0, C_POR, 1'b0, 1'b0);
      end
      w = $urandom_range(2, 8);
      for (int i = 1; i <= w; i++) begin
         tick();
         check_all("same_wait", i, '0, C_POR, 1'b0, 1'b0);
      end
      por_resetn = 1'b1;
      check_sequence(1'b0, 3, 1'b0, C_POR, C_POR, 1'b0, 0, "same_por_seq");
      check_sequence(1'b0, 1, 1'b1, C_POR, C_SOFT, 1'b1, 0, "soft_deferred");
      ack_handshake(1'b0, "deferred_ack");
   endtask

   task automatic test_por_mid_release();
      int t0, w;
      t0 = $urandom_range(HD, HD + GD - 4);
      set_soft(1'b0, 1'b1);
      check_sequence(1'b0, 3, 1'b1, C_SOFT, C_SOFT, 1'b1, 3 + t0, "pre_drop");
      por_resetn = 1'b0;
      set_soft(1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i < 3) check_all("mid_drop", i, stages_for(released(t0 + i, HD, GD)), C_SOFT, 1'b0, 1'b0);
         else       check_all("mid_assert", i, '0, C_POR, 1'b0, 1'b0);
      end
      w = $urandom_range(2, 10);
      for (int i = 1; i <= w; i++) begin
         tick();
         check_all("mid_wait", i, '0, C_POR, 1'b0, 1'b0);
      end
      por_resetn = 1'b1;
      check_sequence(1'b0, 3, 1'b0, C_POR, C_POR, 1'b0, 0, "por_restart");
   endtask

   task automatic test_async_reset_hold();
      int tr;
      tr = $urandom_range(0, HD - 2);
      set_soft(1'b0, 1'b1);
      check_sequence(1'b0, 3, 1'b1, C_POR, C_SOFT, 1'b1, 3 + tr, "pre_reset");
      #3;
      reset = 1'b1;
      #1;
      check_all("async_reset", 0, '0, C_POR, 1'b0, 1'b0);
      set_soft(1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_all("in_reset", i, '0, C_POR, 1'b0, 1'b0);
      end
      reset = 1'b0;
      // two edges to release the internal reset, then the POR synchronizer path
      check_sequence(1'b0, 5, 1'b0, C_POR, C_POR, 1'b0, 0, "post_reset");
   endtask

   initial begin
      reset = 1'b1;
      por_resetn = 1'b0;
      if_d.soft_req = 1'b0;
      if_f.soft_req = 1'b0;
      test_reset();
      test_min_params();
      test_por_startup();
      test_back_to_back();
      test_por_soft_same();
      test_por_mid_release();
      test_async_reset_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the power-on reset produced by the board-level POR counter and turns it into ordered, per-domain active-low resets for the picosoc: flash/memory first, CPU next, peripherals last. It also services a four-phase soft-reset request from an always-on requester (watchdog or host debug interface) and re-runs the full sequence on demand. Sits between the POR block and the SoC top, clocked by the same 48 MHz board clock.

## Interface
- `NSTAGES`, 3: number of sequenced reset domains; stage 0 is released first.
- `HOLD_CLOCKS`, 32: minimum cycles all stages stay asserted before the first release, range 1..65535.
- `STAGE_GAP`, 16: cycles between consecutive stage releases, range 1..65535.
- `clock48`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high; asserts everything immediately, deassertion is synchronized internally with two flops.
- `por_resetn`  in  1  asynchronous active-low reset from the POR block; two-flop synchronized before use.
- `soft_req`  in  1  level soft-reset request; four-phase with `soft_ack`.
- `soft_ack`  out  1  soft-reset completion acknowledge.
- `resetn_stage`  out  NSTAGES  active-low resets, bit k for domain k.
- `seq_busy`  out  1  high whenever any stage is asserted.
- `last_cause`  out  2  01 = POR/`reset`, 10 = soft request; 00 and 11 are unused.

## Operation
- States: WAIT_POR, HOLD, RELEASE, RUN, ACK_WAIT.
- WAIT_POR: all stages asserted. Exit to HOLD when synchronized `por_resetn` is 1. Load the hold counter with 0.
- HOLD: all stages asserted; the counter increments each cycle. Exit to RELEASE on the cycle the counter equals `HOLD_CLOCKS`-1. Stage 0 deasserts on that edge and the gap counter clears.
- RELEASE: stage k+1 deasserts `STAGE_GAP` cycles after stage k. Stages already released stay released. When the last stage deasserts, go to RUN, or to ACK_WAIT if `last_cause`=10.
- ACK_WAIT: `soft_ack`=1. Hold it until `soft_req` is sampled 0, then drop `soft_ack` and go to RUN.
- RUN: all stages released. If `soft_req`=1 and `soft_ack`=0: assert all stages on the next edge, set `last_cause`=10, go to HOLD.
- Synchronized `por_resetn`=0 in any state:
  - assert all stages on the next edge;
  - `last_cause`=01, `soft_ack`=0;
  - go to WAIT_POR.
  - This overrides a simultaneous `soft_req`.
- `soft_req` during WAIT_POR, HOLD or RELEASE is ignored. It is evaluated once RUN is reached.
- `soft_req` dropped before ack while sequencing: the sequence completes; ACK_WAIT exits immediately (ack pulses for one cycle).
- Counters are 16 bits and saturate, never wrap. Gap and hold counters reset on every entry to HOLD.

## Timing
- Values while `reset`=1 or after it: `resetn_stage`=0, `soft_ack`=0, `seq_busy`=1, `last_cause`=01, state WAIT_POR.
- `por_resetn` rise to WAIT_POR exit: 2 edges (synchronizer) + 1.
- Stage 0 release: `HOLD_CLOCKS` edges after HOLD entry.
- Stage k release: stage 0 release + k·`STAGE_GAP`.
- `por_resetn` fall to all stages asserted: at most 3 edges.
- `seq_busy` falls on the same edge as the last stage release. `soft_ack` rises on that same edge.
- Soft request accepted in RUN: stages assert 1 edge after `soft_req` is sampled high.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `reset_seq_pkg`:
  - state encoding;
  - cause codes `CAUSE_POR`=2'b01, `CAUSE_SOFT`=2'b10;
  - counter width constant 16.
- One natural sub-module, `sync2`: a two-flop synchronizer with async active-high clear. It is instantiated for `por_resetn` and `soft_req`, plus one instance for `reset` deassertion.

## Test plan
- `reset` pulse, then `por_resetn` 0→1 at cycle 10 (defaults):
  - `resetn_stage` goes 001, 011, 111 at cycles 10+3+32, +16, +16;
  - `seq_busy` falls with the last release;
  - `last_cause`=01.
- From RUN, raise `soft_req`:
  - all stages are 0 one edge after the request is sampled;
  - the sequence repeats with identical spacing;
  - `soft_ack`=1 with the last release and stays 1 until `soft_req`=0, then falls next edge;
  - `last_cause`=10.
- `por_resetn` low mid-RELEASE (after stage 0 only): all stages are 0 within 3 edges; restart from WAIT_POR with `last_cause`=01.
- `soft_req` and `por_resetn` fall in the same cycle in RUN: POR wins, `soft_ack` is never raised, and `last_cause`=01.
- `reset` asserted asynchronously mid-HOLD: outputs reach reset values without a clock edge. Release requires the full sequence again.
- `HOLD_CLOCKS`=1, `STAGE_GAP`=1: stages release on consecutive edges, and no counter wraps or underflows.
